// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
//
// Read-side engine for a simple dual-port block RAM. A one-cycle start
// command (base address + word count) makes the block walk the RAM read port
// over consecutive addresses, absorb the RAM's one-cycle registered-read
// latency in a 3-entry FIFO, and present the words on a valid/ready stream
// with full backpressure.
//
// Optional feature macro: BRAM_READER_LAST_EN
//   defined   -> m_last_o port exists, flags the final word of a command
//   undefined -> no m_last_o port, all other behaviour identical
//
// Ports
//   clk_i        in   sole clock, shared with the RAM read port
//   rst_i        in   synchronous active-high reset
//   start_i      in   command strobe, only looked at while idle
//   base_addr_i  in   first word address
//   len_i        in   word count, 0 .. 2**RAM_ADDR_BITS
//   busy_o       out  command in progress
//   done_o       out  one-cycle completion pulse
//   en_b_o       out  RAM read enable
//   addr_b_o     out  RAM read address (0 while idle)
//   data_b_i     in   RAM read data, valid the cycle after en_b_o
//   m_valid_o    out  stream word valid
//   m_data_o     out  stream word (0 when not valid)
//   m_ready_i    in   consumer ready
//   m_last_o     out  final word marker (BRAM_READER_LAST_EN only)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start_i
// ST_READ  | RAM reads still to be issued
// ST_DRAIN | all reads issued, words still in flight or buffered
// ---------------------------------------------------------------------------
module bram_stream_reader #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [RAM_ADDR_BITS-1:0] base_addr_i,
    input  logic [RAM_ADDR_BITS:0]   len_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     en_b_o,
    output logic [RAM_ADDR_BITS-1:0] addr_b_o,
    input  logic [RAM_WIDTH-1:0]     data_b_i,
    output logic                     m_valid_o,
    output logic [RAM_WIDTH-1:0]     m_data_o,
    input  logic                     m_ready_i
`ifdef BRAM_READER_LAST_EN
    ,
    output logic                     m_last_o
`endif
);

    localparam int CNT_W = RAM_ADDR_BITS + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]               state_q;
    logic [RAM_ADDR_BITS-1:0] rd_addr_q;
    logic [CNT_W-1:0]         rd_left_q;     // reads still to issue, counts down
    logic [CNT_W-1:0]         len_q;
    logic [CNT_W-1:0]         delivered_q;   // words handed to the consumer
    logic                     rd_pend_q;     // a RAM read is in flight
    logic                     done_q;

    logic [RAM_WIDTH-1:0]     fifo_mem [0:2];
    logic [1:0]               wr_ptr_q;
    logic [1:0]               rd_ptr_q;
    logic [1:0]               fifo_count_q;

    logic [2:0]               occupancy;
    logic                     issue;
    logic                     push;
    logic                     pop;
    logic                     last_word;
    logic                     final_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is only issued when its word is guaranteed a FIFO slot, counting
    // the read already in flight. This keeps the FIFO from overflowing even
    // with the consumer stalled, and still sustains one word per clock when
    // the consumer is always ready (count=1, pend=1 -> issue).
    assign occupancy = {1'b0, fifo_count_q} + {2'b00, rd_pend_q};
    assign issue     = (state_q == ST_READ) && (occupancy <= 3'd2);
    assign push      = rd_pend_q;
    assign m_valid_o = (fifo_count_q != 2'd0);
    assign pop       = m_valid_o && m_ready_i;
    assign last_word = ((delivered_q + CNT_W'(1)) == len_q);
    // The last word can only reach the FIFO head after its read was issued,
    // i.e. once the FSM is already in DRAIN.
    assign final_pop = pop && last_word && (state_q == ST_DRAIN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            rd_addr_q    <= '0;
            rd_left_q    <= '0;
            len_q        <= '0;
            delivered_q  <= '0;
            rd_pend_q    <= 1'b0;
            done_q       <= 1'b0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            fifo_count_q <= 2'd0;
        end else begin
            rd_pend_q <= issue;
            done_q    <= 1'b0;

            if (pop) begin
                delivered_q <= delivered_q + CNT_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= ST_READ;
                            rd_addr_q   <= base_addr_i;
                            rd_left_q   <= len_i;
                            len_q       <= len_i;
                            delivered_q <= '0;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        // Address wraps naturally at the top of the RAM.
                        rd_addr_q <= rd_addr_q + RAM_ADDR_BITS'(1);
                        rd_left_q <= rd_left_q - CNT_W'(1);
                        if (rd_left_q == CNT_W'(1)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (final_pop) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
                2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is only visible while count != 0.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= data_b_i;
        end
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = done_q;
    assign en_b_o   = issue;
    assign addr_b_o = (state_q == ST_IDLE) ? '0 : rd_addr_q;
    assign m_data_o = m_valid_o ? fifo_mem[rd_ptr_q] : '0;

`ifdef BRAM_READER_LAST_EN
    assign m_last_o = m_valid_o && last_word && (state_q == ST_DRAIN);
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_bram_stream_reader
//
// Bench for bram_stream_reader with a registered-read RAM model. A reference
// model keeps, per command, the list of expected read addresses and the
// expected word sequence, and checks every cycle the stream order, hold
// behaviour under backpressure, done/busy timing, in-flight word bound and
// address sequence. m_last_o is checked when BRAM_READER_LAST_EN is defined.
// ---------------------------------------------------------------------------
module tb_bram_stream_reader;

    localparam int W     = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [AW:0]   len_i;
    logic          busy_o;
    logic          done_o;
    logic          en_b_o;
    logic [AW-1:0] addr_b_o;
    logic [W-1:0]  data_b_i;
    logic          m_valid_o;
    logic [W-1:0]  m_data_o;
    logic          m_ready_i;
`ifdef BRAM_READER_LAST_EN
    logic          m_last_o;
`endif

    bram_stream_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .en_b_o      (en_b_o),
        .addr_b_o    (addr_b_o),
        .data_b_i    (data_b_i),
        .m_valid_o   (m_valid_o),
        .m_data_o    (m_data_o),
        .m_ready_i   (m_ready_i)
`ifdef BRAM_READER_LAST_EN
        ,
        .m_last_o    (m_last_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Registered-read RAM
    logic [W-1:0] ram [0:DEPTH-1];
    always @(posedge clk_i) begin
        if (en_b_o) data_b_i <= ram[addr_b_o];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] data_q [$];
    int           addr_q [$];
    bit           m_busy = 0;
    bit           exp_done = 0;
    int           outstanding = 0;
    bit           prev_hold = 0;
    logic [W-1:0] prev_data = '0;
    int           cyc = 0;
    int           cmd_hs = 0;
    int           first_hs = 0;
    int           last_hs = 0;
    int           done_cnt = 0;

    always @(negedge clk_i) begin
        bit hs;
        bit was_busy;
        cyc++;
        hs       = m_valid_o && m_ready_i;
        was_busy = m_busy;

        chk("busy", 32'(busy_o), 32'(m_busy));
        chk("done", 32'(done_o), 32'(exp_done));
        if (done_o === 1'b1) done_cnt++;

        if (en_b_o === 1'b1) begin
            if (addr_q.size() == 0) chk("en_extra", 32'(en_b_o), 32'd0);
            else chk("rd_addr", 32'(addr_b_o), 32'(addr_q.pop_front()));
        end
        if (!m_busy) begin
            chk("idle_valid", 32'(m_valid_o), 32'd0);
            chk("idle_addr", 32'(addr_b_o), 32'd0);
        end
        if (prev_hold) begin
            chk("hold_valid", 32'(m_valid_o), 32'd1);
            chk("hold_data", 32'(m_data_o), 32'(prev_data));
        end
`ifdef BRAM_READER_LAST_EN
        chk("last", 32'(m_last_o), 32'(m_valid_o && (data_q.size() == 1)));
`endif
        if (hs) begin
            if (data_q.size() == 0) chk("hs_extra", 32'(hs), 32'd0);
            else begin
                chk("data", 32'(m_data_o), 32'(data_q.pop_front()));
                if (cmd_hs == 0) first_hs = cyc;
                last_hs = cyc;
                cmd_hs++;
            end
        end

        if (en_b_o === 1'b1) outstanding++;
        if (hs) outstanding--;
        chk("in_flight_le3", 32'(outstanding <= 3), 32'd1);

        exp_done  = 0;
        prev_hold = m_valid_o && !m_ready_i;
        prev_data = m_data_o;
        if (hs && m_busy && data_q.size() == 0 && addr_q.size() == 0) begin
            m_busy   = 0;
            exp_done = 1;
        end
        if (!was_busy && start_i) begin
            if (len_i == '0) exp_done = 1;
            else begin
                m_busy = 1;
                cmd_hs = 0;
                for (int i = 0; i < int'(len_i); i++) begin
                    addr_q.push_back((int'(base_addr_i) + i) % DEPTH);
                    data_q.push_back(ram[(int'(base_addr_i) + i) % DEPTH]);
                end
            end
        end
        if (rst_i) begin
            m_busy      = 0;
            exp_done    = 0;
            outstanding = 0;
            prev_hold   = 0;
            data_q.delete();
            addr_q.delete();
        end
    end

    // ---------------- stimulus ----------------
    int rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 stall then ready
    int stall = 0;

    task automatic step();
        @(posedge clk_i);
        #1;
        case (rdy_mode)
            0: m_ready_i = 1'b1;
            1: m_ready_i = ~m_ready_i;
            2: m_ready_i = 1'($urandom_range(0, 1));
            default: begin
                if (stall > 0) begin
                    m_ready_i = 1'b0;
                    stall--;
                end else m_ready_i = 1'b1;
            end
        endcase
    endtask

    task automatic run_cmd(input logic [AW-1:0] b, input logic [AW:0] l, input int mode);
        int lat;
        int d0;
        bit seen;
        bit got;
        rdy_mode = mode;
        if (mode == 3) stall = 12;
        d0 = done_cnt;
        base_addr_i = b;
        len_i = l;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        base_addr_i = AW'($urandom);
        len_i = (AW+1)'($urandom);
        lat = 0;
        seen = 0;
        got = 0;
        for (int c = 1; c <= 4 * int'(l) + 40; c++) begin
            @(negedge clk_i);
            if (!seen && m_valid_o === 1'b1) begin
                seen = 1;
                lat = c;
            end
            if (done_o === 1'b1) begin
                got = 1;
                break;
            end
            step();
        end
        chk("done_seen", 32'(got), 32'd1);
        if (l == '0) chk("len0_valid", 32'(seen), 32'd0);
        else chk("first_valid_lat", 32'(lat), 32'd3);
        step();
        chk("done_count", 32'(done_cnt - d0), 32'd1);
        if (l != '0) chk("hs_count", 32'(cmd_hs), 32'(l));
        if (mode == 0 && l != '0) chk("burst_span", 32'(last_hs - first_hs), 32'(int'(l) - 1));
    endtask

    initial begin
        int hs_n;
        int d0;
        rst_i = 1'b1;
        start_i = 1'b0;
        base_addr_i = '0;
        len_i = '0;
        m_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) ram[i] = W'($urandom);
        ram[16] = 8'hA0;
        ram[17] = 8'hA1;
        ram[18] = 8'hA2;
        ram[19] = 8'hA3;

        repeat (3) step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_en", 32'(en_b_o), 32'd0);
        chk("rst_addr", 32'(addr_b_o), 32'd0);
        chk("rst_valid", 32'(m_valid_o), 32'd0);
        chk("rst_data", 32'(m_data_o), 32'd0);
`ifdef BRAM_READER_LAST_EN
        chk("rst_last", 32'(m_last_o), 32'd0);
`endif
        step();

        run_cmd(10'h010, 11'd4, 0);
        run_cmd(10'h010, 11'd4, 1);
        run_cmd(10'h3FE, 11'd4, 0);
        run_cmd(10'h000, 11'd0, 2);

        // Abort: len=8, stray start during READ, reset after 3 words.
        rdy_mode = 0;
        base_addr_i = 10'h040;
        len_i = 11'd8;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        hs_n = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk_i);
            if (m_valid_o === 1'b1 && m_ready_i) hs_n++;
            if (hs_n == 3) break;
            step();
            if (c == 1) begin
                start_i = 1'b1;
                base_addr_i = 10'h300;
                len_i = 11'd5;
            end else start_i = 1'b0;
        end
        chk("abort_hs3", 32'(hs_n), 32'd3);
        step();
        d0 = done_cnt;
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            chk("abort_busy", 32'(busy_o), 32'd0);
            chk("abort_valid", 32'(m_valid_o), 32'd0);
            chk("abort_en", 32'(en_b_o), 32'd0);
            chk("abort_data", 32'(m_data_o), 32'd0);
            step();
        end
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_cmd(10'h055, 11'd1, 0);

        run_cmd(10'h000, 11'd1024, 0);
        run_cmd(10'h200, 11'd10, 3);

        for (int n = 0; n < 16; n++) begin
            logic [AW-1:0] b;
            logic [AW:0]   l;
            b = AW'($urandom_range(0, DEPTH - 1));
            l = ($urandom_range(0, 7) == 0) ? '0 : (AW+1)'($urandom_range(1, 40));
            run_cmd(b, l, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
